// File: rtl/row_store.sv
// row_store: playfield rows with 1-cycle read, OR-write and a line-clear pass.
// Define ROW_STORE_FLOOR_EN to make the bottom row a hardwired, never-scanned floor.
module row_store #(
  parameter int ROWS = 20,
  parameter int COLS = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rd_row,
  output logic [0:COLS-1] rd_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_row,
  input  logic [0:COLS-1] wr_mask,
  input  logic            clr_start,
  output logic            ready,
  output logic            done,
  output logic [2:0]      n_lines
);
`ifdef ROW_STORE_FLOOR_EN
  localparam logic [4:0]      TOP = 5'(ROWS - 2);
  localparam logic [0:COLS-1] FLOOR_ROW = '1;
`else
  localparam logic [4:0]      TOP = 5'(ROWS - 1);
  localparam logic [0:COLS-1] FLOOR_ROW = '0;
`endif
  localparam logic [4:0] NROWS = 5'(ROWS);
  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;
  state_t          state, nxt;
  logic [0:COLS-1] mem [ROWS];
  logic [4:0]      s, t;
  logic            full;
  assign full  = &mem[s];
  assign ready = state == IDLE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = clr_start ? SCAN : IDLE;
      SCAN:    nxt = full ? SHIFT : (s == 5'd0 ? DONE : SCAN);
      SHIFT:   nxt = t == 5'd0 ? SCAN : SHIFT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s       <= '0;
      t       <= '0;
      n_lines <= '0;
      done    <= 1'b0;
      rd_data <= '0;
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
      mem[ROWS-1] <= FLOOR_ROW;
    end else begin
      state   <= nxt;
      done    <= state == DONE;
      rd_data <= rd_row < NROWS ? mem[rd_row] : '0;
      case (state)
        IDLE: begin
          if (wr_en && wr_row <= TOP) mem[wr_row] <= mem[wr_row] | wr_mask;
          if (clr_start) begin
            n_lines <= '0;
            s       <= TOP;
          end
        end
        SCAN: begin
          if (full) begin
            n_lines <= n_lines + 3'(n_lines != 3'd7);
            t       <= s;
          end else if (s != 5'd0) begin
            s <= s - 5'd1;
          end
        end
        SHIFT: begin
          // Rows above t slide down one per cycle; the top row refills empty.
          if (t == 5'd0) begin
            mem[0] <= '0;
          end else begin
            mem[t] <= mem[t-5'd1];
            t      <= t - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_row_store.sv
// tb_row_store: scoreboard bench for row_store reads, writes and line-clear passes.
module tb_row_store;
  logic        clk = 0, rst = 1, wr_en = 0, clr_start = 0;
  logic [4:0]  rd_row = 0, wr_row = 0;
  logic [0:13] wr_mask = 0, rd_data;
  logic        ready, done;
  logic [2:0]  n_lines;
  always #5 clk = ~clk;
  row_store dut (.clk(clk), .rst(rst), .rd_row(rd_row), .rd_data(rd_data),
                 .wr_en(wr_en), .wr_row(wr_row), .wr_mask(wr_mask),
                 .clr_start(clr_start), .ready(ready), .done(done), .n_lines(n_lines));
`ifdef ROW_STORE_FLOOR_EN
  localparam int TOP = 18;
`else
  localparam int TOP = 19;
`endif
  logic [0:13] model [20];
  logic [0:13] exp_q [$];
  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 20; i++) model[i] = '0;
    if (TOP == 18) model[19] = '1;
  endtask

  function automatic logic [0:13] exp_row(input int r);
    return r < 20 ? model[r] : 14'h0;
  endfunction

  task automatic sweep(input string tag);
    for (int r = 0; r <= 21; r++) begin
      rd_row = 5'(r);
      exp_q.push_back(exp_row(r));
      tick;
      check($sformatf("%s_row%0d", tag, r), 32'(rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wr(input int r, input logic [0:13] m);
    wr_en = 1; wr_row = 5'(r); wr_mask = m;
    tick;
    wr_en = 0;
    if (r <= TOP) model[r] = model[r] | m;
  endtask

  // Remove full rows, compact survivors downward; the k-th removal (bottom-up)
  // from original row r is found at row r+k, costing r+k+1 shifts plus a re-scan.
  task automatic model_clear(output int n, output int lat);
    logic [0:13] nw [20];
    int k, dst;
    nw = model; k = 0; dst = TOP; lat = TOP + 2;
    for (int r = TOP; r >= 0; r--) begin
      if (&model[r]) begin
        lat += r + k + 2;
        k++;
      end else begin
        nw[dst] = model[r];
        dst--;
      end
    end
    for (int r = dst; r >= 0; r--) nw[r] = '0;
    n = k > 7 ? 7 : k;
    model = nw;
  endtask

  task automatic run_clear(input string tag, input bit poke);
    int n, lat, k, extra;
    model_clear(n, lat);
    clr_start = 1;
    tick;
    clr_start = 0;
    check({tag, "_busy"}, 32'(ready), 0);
    k = 0;
    while (!done && k < 300) begin
      if (poke && k == 3) begin
        wr_en = 1; wr_row = 2; wr_mask = '1; clr_start = 1;
      end
      tick;
      wr_en = 0; clr_start = 0;
      k++;
    end
    check({tag, "_lat"}, 32'(k), 32'(lat));
    check({tag, "_n"}, 32'(n_lines), 32'(n));
    check({tag, "_ready"}, 32'(ready), 1);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (done) extra++;
    end
    check({tag, "_pulses"}, 32'(extra), 0);
    check({tag, "_n_hold"}, 32'(n_lines), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    model_reset;
    tick; tick;
    rst = 0;
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_ready", 32'(ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_n", 32'(n_lines), 0);
    sweep("reset");
    wr(5, 14'h00F0);
    wr(5, 14'h0F00);
    wr(19, 14'h0003);
    wr(25, 14'h3FFF);
    sweep("write");
    wr(18, 14'h3FFF);
    wr(17, 14'h0001);
    run_clear("one", 0);
    sweep("one");
    run_clear("busy", 1);
    sweep("busy");
    wr(17, 14'h3FFF);
    wr(18, 14'h3FFF);
    wr(16, 14'h2000);
    run_clear("two", 0);
    sweep("two");
    wr(17, 14'h3FFF);
    wr(18, 14'h3FFF);
    clr_start = 1;
    tick;
    clr_start = 0;
    repeat (5) tick;
    rst = 1;
    tick;
    rst = 0;
    check("abort_ready", 32'(ready), 1);
    check("abort_n", 32'(n_lines), 0);
    check("abort_done", 32'(done), 0);
    model_reset;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (done) pulses++;
    end
    check("abort_pulses", 32'(pulses), 0);
    sweep("abort");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
